// File: rtl/universal_shift_reg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg
//
// WIDTH-bit register with single-cycle parallel load and multi-step shifts
// (SHL, SHR, SAR, ROL, ROR) executed one bit per clock. A start/busy/done
// handshake lets a controller issue a shift-by-amt command and wait for it.
//
// Ports
//   clk    in   1      clock, rising edge
//   rst    in   1      asynchronous active-high reset
//   start  in   1      command strobe, sampled only while idle
//   op     in   3      0 LOAD, 1 SHL, 2 SHR, 3 SAR, 4 ROL, 5 ROR, 6-7 reserved
//   amt    in   CNT_W  number of single-bit steps (ignored for LOAD)
//   d      in   WIDTH  parallel load data
//   sin    in   1      serial fill bit for SHL/SHR, sampled every step
//   q      out  WIDTH  register contents
//   sout   out  1      last bit shifted out
//   busy   out  1      high while a multi-step command runs
//   done   out  1      one-cycle completion pulse
// -----------------------------------------------------------------------------

// Per-bit next-value selector built from 2:1 muxes:
//   direction mux (low neighbour vs high neighbour),
//   then shift-or-hold mux, then load-or-other mux.
module usr_bit_cell (
    input  logic i_cur,      // current value of this bit
    input  logic i_load_d,   // parallel load value
    input  logic i_from_lo,  // value arriving on a left shift
    input  logic i_from_hi,  // value arriving on a right shift
    input  logic i_sel_load,
    input  logic i_sel_left,
    input  logic i_sel_right,
    output logic o_nxt
);
    logic w_dir;
    logic w_shift_or_hold;

    assign w_dir           = i_sel_left ? i_from_lo : i_from_hi;
    assign w_shift_or_hold = (i_sel_left | i_sel_right) ? w_dir : i_cur;
    assign o_nxt           = i_sel_load ? i_load_d : w_shift_or_hold;
endmodule

module universal_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] amt,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);
    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_SHL  = 3'd1;
    localparam logic [2:0] OP_SHR  = 3'd2;
    localparam logic [2:0] OP_SAR  = 3'd3;
    localparam logic [2:0] OP_ROL  = 3'd4;
    localparam logic [2:0] OP_ROR  = 3'd5;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    logic             r_state;
    logic [2:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_q;
    logic             r_sout;
    logic             r_busy;
    logic             r_done;

    logic             w_idle_start;
    logic             w_load;
    logic             w_step;
    logic             w_left;
    logic             w_right;
    logic             w_fill_l;   // enters bit 0 on a left step
    logic             w_fill_r;   // enters bit WIDTH-1 on a right step
    logic             w_out_bit;
    logic             w_is_shift_op;
    logic [WIDTH-1:0] w_from_lo;
    logic [WIDTH-1:0] w_from_hi;
    logic [WIDTH-1:0] w_q_nxt;

    assign w_idle_start  = (r_state == ST_IDLE) && start;
    assign w_load        = w_idle_start && (op == OP_LOAD);
    assign w_step        = (r_state == ST_SHIFT);
    assign w_is_shift_op = (op >= OP_SHL) && (op <= OP_ROR);

    // Direction comes from the latched op, so op changes while busy are inert.
    assign w_left  = w_step && ((r_op == OP_SHL) || (r_op == OP_ROL));
    assign w_right = w_step && ((r_op == OP_SHR) || (r_op == OP_SAR) ||
                                (r_op == OP_ROR));

    // ROL recirculates the MSB; SHL takes the live serial bit.
    assign w_fill_l = (r_op == OP_ROL) ? r_q[WIDTH-1] : sin;

    always_comb begin
        w_fill_r = sin;
        case (r_op)
            OP_SAR:  w_fill_r = r_q[WIDTH-1];
            OP_ROR:  w_fill_r = r_q[0];
            default: w_fill_r = sin;
        endcase
    end

    assign w_out_bit = w_left ? r_q[WIDTH-1] : r_q[0];

    // Neighbour wiring; the end bits receive the fill values.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_lo_end
                assign w_from_lo[gi] = w_fill_l;
            end else begin : g_lo_mid
                assign w_from_lo[gi] = r_q[gi-1];
            end

            if (gi == WIDTH-1) begin : g_hi_end
                assign w_from_hi[gi] = w_fill_r;
            end else begin : g_hi_mid
                assign w_from_hi[gi] = r_q[gi+1];
            end

            usr_bit_cell u_cell (
                .i_cur       (r_q[gi]),
                .i_load_d    (d[gi]),
                .i_from_lo   (w_from_lo[gi]),
                .i_from_hi   (w_from_hi[gi]),
                .i_sel_load  (w_load),
                .i_sel_left  (w_left),
                .i_sel_right (w_right),
                .o_nxt       (w_q_nxt[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_LOAD;
            r_cnt   <= '0;
            r_sout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        // Only a shift with a nonzero count leaves IDLE;
                        // LOAD, amt=0 and reserved ops complete at once.
                        if (w_is_shift_op && (amt != '0)) begin
                            r_op    <= op;
                            r_cnt   <= amt;
                            r_busy  <= 1'b1;
                            r_state <= ST_SHIFT;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_cnt  <= r_cnt - 1'b1;
                    r_sout <= w_out_bit;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign q    = r_q;
    assign sout = r_sout;
    assign busy = r_busy;
    assign done = r_done;
endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg (WIDTH=8, CNT_W=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_universal_shift_reg;
    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] op;
    logic [3:0] amt;
    logic [7:0] d;
    logic       sin;
    logic [7:0] q;
    logic       sout;
    logic       busy;
    logic       done;

    int n_chk = 0;
    int n_err = 0;

    universal_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .amt   (amt),
        .d     (d),
        .sin   (sin),
        .q     (q),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for exactly one edge (edge 0); returns just after edge 0.
    task automatic issue(input logic [2:0] o, input logic [3:0] a, input logic [7:0] dd);
        op    = o;
        amt   = a;
        d     = dd;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] dd);
        issue(3'd0, 4'd0, dd);
        chk("load_q", {24'd0, q}, {24'd0, dd});
        chk("load_done", {31'd0, done}, 32'd1);
        chk("load_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("load_done_clr", {31'd0, done}, 32'd0);
    endtask

    logic [7:0] exp_q [0:2];
    logic       exp_s [0:2];

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'd0; amt = 4'd0; d = 8'd0; sin = 1'b0;
        #12;
        chk("rst_q", {24'd0, q}, 32'd0);
        chk("rst_sout", {31'd0, sout}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // LOAD A5
        do_load(8'hA5);
        chk("load_sout", {31'd0, sout}, 32'd0);

        // SHL by 3, sin=1
        exp_q[0] = 8'h4B; exp_q[1] = 8'h97; exp_q[2] = 8'h2F;
        exp_s[0] = 1'b1;  exp_s[1] = 1'b0;  exp_s[2] = 1'b1;
        sin = 1'b1;
        issue(3'd1, 4'd3, 8'h00);
        chk("shl_busy0", {31'd0, busy}, 32'd1);
        chk("shl_done0", {31'd0, done}, 32'd0);
        chk("shl_q0", {24'd0, q}, 32'hA5);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("shl_q", {24'd0, q}, {24'd0, exp_q[i]});
            chk("shl_sout", {31'd0, sout}, {31'd0, exp_s[i]});
            chk("shl_busy", {31'd0, busy}, (i < 2) ? 32'd1 : 32'd0);
            chk("shl_done", {31'd0, done}, (i < 2) ? 32'd0 : 32'd1);
        end
        tick();
        chk("shl_done_clr", {31'd0, done}, 32'd0);

        // SAR by 2 from 96
        do_load(8'h96);
        exp_q[0] = 8'hCB; exp_q[1] = 8'hE5;
        exp_s[0] = 1'b0;  exp_s[1] = 1'b1;
        sin = 1'b0;
        issue(3'd3, 4'd2, 8'h00);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("sar_q", {24'd0, q}, {24'd0, exp_q[i]});
            chk("sar_sout", {31'd0, sout}, {31'd0, exp_s[i]});
        end
        chk("sar_done", {31'd0, done}, 32'd1);
        tick();
        chk("sar_done_clr", {31'd0, done}, 32'd0);

        // ROR by 9 from 81, with an ignored mid-command start
        do_load(8'h81);
        issue(3'd5, 4'd9, 8'h00);
        for (int i = 1; i <= 9; i++) begin
            if (i == 3) begin
                op = 3'd0; d = 8'hFF; amt = 4'd2; start = 1'b1;
            end else begin
                start = 1'b0; op = 3'd1; amt = 4'd1; d = 8'h00;
            end
            tick();
            if (i < 9) begin
                chk("ror_busy", {31'd0, busy}, 32'd1);
                chk("ror_done", {31'd0, done}, 32'd0);
            end
        end
        start = 1'b0;
        chk("ror_q", {24'd0, q}, 32'hC0);
        chk("ror_sout", {31'd0, sout}, 32'd1);
        chk("ror_busy_end", {31'd0, busy}, 32'd0);
        chk("ror_done_end", {31'd0, done}, 32'd1);
        tick();
        chk("ror_done_clr", {31'd0, done}, 32'd0);

        // SHR amt=0 and reserved op 6: immediate done, no change
        issue(3'd2, 4'd0, 8'h00);
        chk("shr0_done", {31'd0, done}, 32'd1);
        chk("shr0_busy", {31'd0, busy}, 32'd0);
        chk("shr0_q", {24'd0, q}, 32'hC0);
        tick();
        chk("shr0_done_clr", {31'd0, done}, 32'd0);
        issue(3'd6, 4'd4, 8'h55);
        chk("rsv_done", {31'd0, done}, 32'd1);
        chk("rsv_busy", {31'd0, busy}, 32'd0);
        chk("rsv_q", {24'd0, q}, 32'hC0);
        chk("rsv_sout", {31'd0, sout}, 32'd1);
        tick();

        // Async reset in the middle of SHR by 5
        sin = 1'b0;
        issue(3'd2, 4'd5, 8'h00);
        tick();
        tick();
        chk("shr_mid_q", {24'd0, q}, 32'h30);
        #3 rst = 1'b1;
        #1;
        chk("arst_q", {24'd0, q}, 32'd0);
        chk("arst_sout", {31'd0, sout}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        tick();
        #2 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_done", {31'd0, done}, 32'd0);
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
        end
        do_load(8'h3C);

        // ROL by 1 with sin=1 (rotate must ignore sin), then SHR fill with sin=1
        sin = 1'b1;
        issue(3'd4, 4'd1, 8'h00);
        tick();
        chk("rol_q", {24'd0, q}, 32'h78);
        chk("rol_sout", {31'd0, sout}, 32'd0);
        chk("rol_done", {31'd0, done}, 32'd1);
        // back-to-back: start during the done cycle is accepted
        issue(3'd2, 4'd2, 8'h00);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("shr_q1", {24'd0, q}, 32'hBC);
        tick();
        chk("shr_q2", {24'd0, q}, 32'hDE);
        chk("shr_sout", {31'd0, sout}, 32'd0);
        chk("shr_done", {31'd0, done}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
